nes_ir_frame_receiver: RTL and testbench

//   Receive side of the NES wireless remote link. Recovers the 32-slot serial frame sent by the remote,

---
 rtl/nes_ir_frame_receiver_if.sv | 34 +++
 rtl/nes_ir_frame_receiver.sv | 168 ++++++++++++++++
 tb/tb_nes_ir_frame_receiver.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_ir_frame_receiver_if.sv
// Button-link bundle between the IR demodulator, the frame receiver and
// the button consumer.
//
// Handshake: there is no back-pressure. Valid_Out is a one-cycle strobe.
// When Valid_Out is high, Buttons_Out already holds the new frame. That
// value stays stable until the next Valid_Out. Error_Out is a one-cycle
// strobe that never coincides with Valid_Out. The consumer must sample
// on the strobe cycle, or read Buttons_Out at any time as the last good
// frame.
interface nes_ir_frame_receiver_if;
  logic       Serial_In;
  logic [7:0] Buttons_Out;
  logic       Valid_Out;
  logic       Error_Out;
  logic       Locked_Out;

  // Receiver side: consumes the serial stream and drives the button results.
  modport master (
    input  Serial_In,
    output Buttons_Out,
    output Valid_Out,
    output Error_Out,
    output Locked_Out
  );

  // Source/consumer side: drives the serial stream and reads the results.
  modport slave (
    output Serial_In,
    input  Buttons_Out,
    input  Valid_Out,
    input  Error_Out,
    input  Locked_Out
  );
endinterface

// File: rtl/nes_ir_frame_receiver.sv
// NES wireless remote frame receiver.
// Oversamples the demodulated IR stream and re-phases on every edge. It takes
// one sample per slot and keeps the last 32 slots in a window. The window is
// checked against the frame format: a 16-slot sync tail, plus 8 button pairs
// whose two slots must agree. The receiver hunts for frame alignment, then
// checks every 32nd slot while locked. It drops lock after MAX_MISSES bad
// frames in a row.
module nes_ir_frame_receiver #(
  parameter int OSR        = 4,
  parameter int MAX_MISSES = 2
) (
  input  logic                           Clk_In,
  input  logic                           Reset_In,
  nes_ir_frame_receiver_if.master        bus,
  output logic                           dbg_state_o,
  output logic [31:0]                    dbg_window_o
);

  localparam int PW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int MW = (MAX_MISSES > 1) ? $clog2(MAX_MISSES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] PHASE_MID  = PW'(OSR / 2);
  localparam logic [MW-1:0] MISS_LAST  = MW'(MAX_MISSES - 1);
  // Slots 16..31 with slot 16 in the MSB; slot 31 is the newest sample (bit 0).
  localparam logic [15:0]   SYNC_WORD  = 16'b0000_0000_0011_0011;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Window layout: slot k of the frame sits at bit 31-k once slot 31 is in.
  function automatic logic window_ok(input logic [31:0] w);
    logic ok;
    ok = (w[15:0] == SYNC_WORD);
    for (int i = 0; i < 8; i++) begin
      if (w[31 - 2*i] != w[30 - 2*i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Button i is the even slot 2i of its pair.
  function automatic logic [7:0] window_buttons(input logic [31:0] w);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = w[31 - 2*i];
    end
    return b;
  endfunction

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_s_q, prev_s_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   shift_q, shift_d;
  logic [4:0]    slot_q, slot_d;
  logic [MW-1:0] miss_q, miss_d;
  state_t        state_q, state_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  logic          s;
  logic          edge_det;
  logic          sample;
  logic          frame_good;
  logic [7:0]    frame_buttons;

  // Input path: synchronize, detect transitions, re-phase and pick mid-slot samples.
  always_comb begin
    sync1_d  = bus.Serial_In;
    sync2_d  = sync1_q;
    s        = sync2_q;
    prev_s_d = s;
    edge_det = s ^ prev_s_q;
    if (edge_det) begin
      phase_d = '0;
    end else if (phase_q == PHASE_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
    sample        = (phase_d == PHASE_MID);
    shift_d       = sample ? {shift_q[30:0], s} : shift_q;
    frame_good    = window_ok(shift_d);
    frame_buttons = window_buttons(shift_d);
  end

  // Lock FSM: hunt on every sample, then check once per 32 samples while locked.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    miss_d    = miss_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    if (sample) begin
      unique case (state_q)
        ST_HUNT: begin
          if (frame_good) begin
            state_d   = ST_LOCKED;
            slot_d    = 5'd0;
            miss_d    = '0;
            buttons_d = frame_buttons;
            valid_d   = 1'b1;
          end
        end
        ST_LOCKED: begin
          slot_d = slot_q + 5'd1;
          if (slot_q == 5'd31) begin
            if (frame_good) begin
              buttons_d = frame_buttons;
              valid_d   = 1'b1;
              miss_d    = '0;
            end else begin
              error_d = 1'b1;
              if (miss_q == MISS_LAST) begin
                state_d = ST_HUNT;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + MW'(1);
              end
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and datapath registers; reset also wins over a same-cycle edge.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_s_q  <= 1'b0;
      phase_q   <= '0;
      shift_q   <= '0;
      slot_q    <= 5'd0;
      miss_q    <= '0;
      state_q   <= ST_HUNT;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_s_q  <= prev_s_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      slot_q    <= slot_d;
      miss_q    <= miss_d;
      state_q   <= state_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign bus.Buttons_Out = buttons_q;
  assign bus.Valid_Out   = valid_q;
  assign bus.Error_Out   = error_q;
  assign bus.Locked_Out  = (state_q == ST_LOCKED);
  assign dbg_state_o     = state_q;
  assign dbg_window_o    = shift_q;

endmodule

// File: tb/tb_nes_ir_frame_receiver.sv
// Bench for the NES IR frame receiver.
// Builds each stimulus segment as a per-cycle waveform of transmitted slots.
// A slot-level reference model predicts every cycle's outputs: sample points
// come from edge-relative arithmetic, and frames are judged by slot index.
// The predictions go through a 3-deep expected queue to cover the
// synchronizer plus the output register.
module tb_nes_ir_frame_receiver;
  localparam int OSR        = 4;
  localparam int MAX_MISSES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_ir_frame_receiver_if bus();
  logic        dbg_state;
  logic [31:0] dbg_window;

  nes_ir_frame_receiver #(.OSR(OSR), .MAX_MISSES(MAX_MISSES)) dut (
    .Clk_In       (clk),
    .Reset_In     (rst),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_window_o (dbg_window)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int err_cnt = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_hist[$];   // last 32 samples, m_hist[k] = slot k of the window
  bit         m_locked;
  int         m_slot;
  int         m_miss;
  int         m_last_edge;
  bit         m_prev;
  logic [7:0] m_buttons;

  function automatic bit slot_is_one_in_sync(input int k);
    return (k == 26) || (k == 27) || (k == 30) || (k == 31);
  endfunction

  function automatic bit frame_ok();
    for (int k = 16; k < 32; k++) begin
      if (m_hist[k] != slot_is_one_in_sync(k)) return 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_hist[2*i] != m_hist[2*i+1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] frame_buttons();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = m_hist[2*i];
    return b;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < 32; k++) m_hist.push_back(1'b0);
    m_locked    = 1'b0;
    m_slot      = 0;
    m_miss      = 0;
    m_buttons   = 8'h00;
    m_prev      = 1'b0;
    // Cycle -2 after release behaves as phase 1, as if an edge came one cycle earlier.
    m_last_edge = -3;
  endtask

  // Processes one synchronized input cycle; returns {locked, valid, error, buttons}.
  function automatic logic [10:0] model_step(input int n, input bit b);
    bit v;
    bit e;
    v = 1'b0;
    e = 1'b0;
    if (b != m_prev) m_last_edge = n;
    m_prev = b;
    if (((n - m_last_edge) % OSR) == OSR / 2) begin
      m_hist.push_back(b);
      void'(m_hist.pop_front());
      if (!m_locked) begin
        if (frame_ok()) begin
          m_locked  = 1'b1;
          m_slot    = 0;
          m_miss    = 0;
          m_buttons = frame_buttons();
          v         = 1'b1;
        end
      end else begin
        if (m_slot == 31) begin
          if (frame_ok()) begin
            m_buttons = frame_buttons();
            m_miss    = 0;
            v         = 1'b1;
          end else begin
            e = 1'b1;
            m_miss++;
            if (m_miss >= MAX_MISSES) begin
              m_locked = 1'b0;
              m_miss   = 0;
            end
          end
        end
        m_slot = (m_slot + 1) % 32;
      end
    end
    return {m_locked, v, e, m_buttons};
  endfunction

  // ---------------- stimulus building ----------------
  bit wave_q[$];

  // period 0 picks a random 3..5 cycle width per slot.
  task automatic add_slots(input logic [7:0] b, input int period, input int k0, input int k1,
                           input int bad_slot, input bit bad_val);
    bit v;
    int p;
    for (int k = k0; k <= k1; k++) begin
      v = (k < 16) ? b[k/2] : slot_is_one_in_sync(k);
      if (k == bad_slot) v = bad_val;
      p = (period == 0) ? int'($urandom_range(3, 5)) : period;
      repeat (p) wave_q.push_back(v);
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input int period);
    add_slots(b, period, 0, 31, -1, 1'b0);
  endtask

  task automatic add_idle(input int n);
    repeat (n) wave_q.push_back(1'b0);
  endtask

  // ---------------- driver ----------------
  int         seg_valid_at[$];
  int         seg_err;
  int         seg_unlocks;
  logic       seg_locked_last;
  logic [7:0] seg_buttons_last;

  task automatic run_segment(input string name, input int rst_cycles);
    logic [10:0] got;
    logic        prev_locked;
    seg_valid_at.delete();
    seg_err     = 0;
    seg_unlocks = 0;
    @(negedge clk);
    rst           = 1'b1;
    bus.Serial_In = 1'b0;
    repeat (rst_cycles - 1) @(negedge clk);
    model_reset();
    exp_q.delete();
    exp_q.push_back(11'd0);
    exp_q.push_back(model_step(-2, 1'b0));
    exp_q.push_back(model_step(-1, 1'b0));
    prev_locked = 1'b0;
    for (int n = 0; n < wave_q.size(); n++) begin
      @(negedge clk);
      rst           = 1'b0;
      bus.Serial_In = wave_q[n];
      exp_q.push_back(model_step(n, wave_q[n]));
      got = {bus.Locked_Out, bus.Valid_Out, bus.Error_Out, bus.Buttons_Out};
      check(name, 32'(got), 32'(exp_q.pop_front()));
      if (bus.Valid_Out) seg_valid_at.push_back(n);
      if (bus.Error_Out) seg_err++;
      if (prev_locked && !bus.Locked_Out) seg_unlocks++;
      prev_locked = bus.Locked_Out;
    end
    seg_locked_last  = bus.Locked_Out;
    seg_buttons_last = bus.Buttons_Out;
    wave_q.delete();
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [7:0] rb;
    bus.Serial_In = 1'b0;

    // 1: three clean 8'h81 frames.
    add_idle(8);
    repeat (3) add_frame(8'h81, OSR);
    add_idle(8);
    run_segment("t1_cycle", 3);
    check("t1_valid_count", seg_valid_at.size(), 3);
    if (seg_valid_at.size() >= 3) begin
      // Slot 31 of frame 1 midpoint is wave index 8+128-2 = 134; outputs follow 3 cycles later.
      check("t1_latency", seg_valid_at[0], 137);
      check("t1_gap1", seg_valid_at[1] - seg_valid_at[0], 32 * OSR);
      check("t1_gap2", seg_valid_at[2] - seg_valid_at[1], 32 * OSR);
    end
    check("t1_errors", seg_err, 0);
    check("t1_buttons", seg_buttons_last, 8'h81);
    check("t1_locked", seg_locked_last, 1);

    // 2: one bad sync slot, then a good 8'h10 frame.
    add_idle(8);
    repeat (2) add_frame(8'h81, OSR);
    add_slots(8'h81, OSR, 0, 31, 26, 1'b0);
    add_frame(8'h10, OSR);
    add_idle(8);
    run_segment("t2_cycle", 2);
    check("t2_valid_count", seg_valid_at.size(), 3);
    check("t2_errors", seg_err, 1);
    check("t2_unlocks", seg_unlocks, 0);
    check("t2_buttons", seg_buttons_last, 8'h10);
    check("t2_locked", seg_locked_last, 1);

    // 3: two bad button pairs in a row lose lock, then relock.
    add_idle(8);
    add_frame(8'h81, OSR);
    repeat (2) add_slots(8'h81, OSR, 0, 31, 6, 1'b1);
    add_frame(8'h81, OSR);
    add_idle(8);
    run_segment("t3_cycle", 2);
    check("t3_valid_count", seg_valid_at.size(), 2);
    check("t3_errors", seg_err, 2);
    check("t3_unlocks", seg_unlocks, 1);
    check("t3_locked", seg_locked_last, 1);

    // 4: constant low input never locks.
    add_idle(500);
    run_segment("t4_cycle", 2);
    check("t4_valid_count", seg_valid_at.size(), 0);
    check("t4_errors", seg_err, 0);
    check("t4_locked", seg_locked_last, 0);

    // 5: slow transmitter, 5-cycle slots, random buttons.
    add_idle(8);
    repeat (4) begin
      rb = 8'($urandom);
      add_frame(rb, 5);
    end
    add_idle(8);
    run_segment("t5_cycle", 2);

    // 6: reset pulse mid-frame while locked on 8'hFF, then relock.
    add_idle(8);
    repeat (2) add_frame(8'hFF, OSR);
    add_slots(8'hFF, OSR, 0, 13, -1, 1'b0);
    run_segment("t6a_cycle", 2);
    check("t6_locked_before", seg_locked_last, 1);
    check("t6_buttons_before", seg_buttons_last, 8'hFF);
    add_slots(8'hFF, OSR, 14, 31, -1, 1'b0);
    repeat (2) add_frame(8'hFF, OSR);
    add_idle(8);
    run_segment("t6b_cycle", 1);
    check("t6_locked_after", seg_locked_last, 1);
    check("t6_buttons_after", seg_buttons_last, 8'hFF);

    // 7: random buttons, random slot jitter and occasional corrupted slots.
    for (int r = 0; r < 4; r++) begin
      add_idle($urandom_range(1, 12));
      repeat (6) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          add_slots(rb, OSR, 0, 31, $urandom_range(0, 31), 1'($urandom));
        end else begin
          add_frame(rb, ($urandom_range(0, 3) == 0) ? 0 : OSR);
        end
      end
      add_idle(8);
      run_segment("t7_cycle", $urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
